// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state encoding and constants for the SAR ADC controller
package sar_pkg;
  localparam int SAR_WIDTH = 12;
  localparam logic [SAR_WIDTH-1:0] SAR_MIDSCALE = 12'h7FF;
  localparam int SAR_PERIOD = 32;
  localparam int SAR_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CONVERT,
    ST_CAPTURE,
    ST_WAIT
  } sar_state_t;
endpackage

// File: rtl/sar_frame_timer.sv
// rtl/sar_frame_timer.sv - free-running conversion frame counter with wrap pulse
module sar_frame_timer
  import sar_pkg::*;
#(
  parameter int PERIOD = SAR_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic wrap
);
  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  // wrap marks the edge on which the counter returns to zero
  assign wrap = en && !clr && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end
endmodule

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - conversion sequencer, sample-and-hold and digital comparator
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH   = SAR_WIDTH,
  parameter int PERIOD  = SAR_PERIOD,
  parameter int TIMEOUT = SAR_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] vin,
  output logic             sar_s,
  output logic             sar_d,
  input  logic [WIDTH-1:0] sar_q,
  input  logic             sar_cc,
  output logic [WIDTH-1:0] sample,
  output logic             sample_valid,
  output logic             busy,
  output logic             error
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  sar_state_t       state, state_nx;
  logic [WIDTH-1:0] hold;
  logic [TW-1:0]    tcnt;
  logic             restart;
  logic             wrap;
  logic             timed_out;
  logic             in_idle;

  assign sar_d     = (hold >= sar_q);
  assign timed_out = (tcnt == TLAST);
  assign in_idle   = (state == ST_IDLE);

  sar_frame_timer #(.PERIOD(PERIOD)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (enable),
    .clr     (in_idle),
    .wrap    (wrap)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (enable) state_nx = ST_START;
      ST_START:   state_nx = ST_CONVERT;
      ST_CONVERT: begin
        if (!sar_cc)        state_nx = ST_CAPTURE;
        else if (timed_out) state_nx = ST_WAIT;
      end
      ST_CAPTURE: state_nx = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!enable)   state_nx = ST_IDLE;
        else if (wrap) state_nx = ST_START;
      end
      default:    state_nx = ST_IDLE;
    endcase
  end

  // sar_s and busy are registered from the next state so only sar_d is combinational
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      sar_s        <= 1'b0;
      busy         <= 1'b0;
      hold         <= '0;
      tcnt         <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      error        <= 1'b0;
      restart      <= 1'b0;
    end else begin
      state        <= state_nx;
      sar_s        <= (state_nx == ST_CONVERT) || (state_nx == ST_CAPTURE) ||
                      (state_nx == ST_WAIT);
      busy         <= (state_nx == ST_START) || (state_nx == ST_CONVERT) ||
                      (state_nx == ST_CAPTURE);
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: restart <= 1'b1;
        ST_START: begin
          hold    <= vin;
          tcnt    <= '0;
          restart <= 1'b0;
          if (restart) error <= 1'b0;
        end
        ST_CONVERT: begin
          tcnt <= tcnt + TW'(1);
          if (!sar_cc) begin
            sample       <= sar_q;
            sample_valid <= 1'b1;
          end else if (timed_out) begin
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - directed and randomized bench with a behavioural SAR register
module tb_sar_adc_ctrl;
  import sar_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] vin = '0;
  logic        sar_s, sar_d;
  logic [11:0] sample;
  logic        sample_valid, busy, error;

  logic [11:0] sq = '0;
  logic [11:0] sres = '0;
  logic        scc = 1'b1;
  int          sb = -1;
  logic        stuck = 1'b0;

  int errors = 0;
  int checks = 0;
  int d_cnt = 0;
  int v_cnt = 0;
  logic mon_d = 1'b0;

  sar_adc_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .vin          (vin),
    .sar_s        (sar_s),
    .sar_d        (sar_d),
    .sar_q        (sq),
    .sar_cc       (scc),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  // SAR register: first decision is taken against the mid-scale reset code
  always @(posedge clk) begin : sar_model
    logic [11:0] r;
    if (!sar_s) begin
      sq   <= SAR_MIDSCALE;
      sres <= '0;
      sb   <= 11;
      scc  <= 1'b1;
    end else if (sb >= 0) begin
      r = sres | ({11'd0, sar_d} << sb);
      sres <= r;
      sq   <= (sb > 0) ? (r | (12'd1 << (sb - 1))) : r;
      if (sb == 0 && !stuck) scc <= 1'b0;
      sb <= sb - 1;
    end
  end

  always @(negedge clk) begin
    if (mon_d && sar_s && scc && sar_d) d_cnt++;
    if (sample_valid) v_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From one sample_valid cycle, the next one is exactly 32 clocks later
  task automatic next_sample(input string tag, input logic [11:0] exp);
    tick(31);
    chk({tag, "_early"}, sample_valid, 1'b0);
    tick(1);
    chk({tag, "_valid"}, sample_valid, 1'b1);
    chk({tag, "_sample"}, sample, exp);
  endtask

  function automatic logic [11:0] rand_code();
    logic [11:0] v;
    v = 12'($urandom_range(0, 4095));
    if (v == SAR_MIDSCALE) v = 12'h7FE;
    return v;
  endfunction

  initial begin
    logic [11:0] v;
    tick(3);
    chk("rst_sar_s", sar_s, 1'b0);
    chk("rst_sample", sample, 12'h000);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_error", error, 1'b0);
    reset_n = 1'b1;
    tick(2);
    chk("idle_busy", busy, 1'b0);

    // first conversion: START at E0, sample at E14
    vin = 12'h800;
    enable = 1'b1;
    tick(1);
    chk("e0_busy", busy, 1'b1);
    chk("e0_sar_s", sar_s, 1'b0);
    tick(1);
    chk("e1_sar_s", sar_s, 1'b1);
    tick(12);
    chk("e13_valid", sample_valid, 1'b0);
    tick(1);
    chk("e14_valid", sample_valid, 1'b1);
    chk("e14_sample", sample, 12'h800);
    chk("e14_busy", busy, 1'b1);
    tick(1);
    chk("e15_valid", sample_valid, 1'b0);
    chk("e15_busy", busy, 1'b0);
    tick(30);
    chk("period_early", sample_valid, 1'b0);
    tick(1);
    chk("period_valid", sample_valid, 1'b1);
    chk("period_sample", sample, 12'h800);

    // extremes and comparator activity
    vin = 12'h000; d_cnt = 0; mon_d = 1'b1;
    next_sample("zero", 12'h000);
    mon_d = 1'b0;
    chk("zero_d_count", d_cnt, 0);
    vin = 12'hFFF; d_cnt = 0; mon_d = 1'b1;
    next_sample("full", 12'hFFF);
    mon_d = 1'b0;
    chk("full_d_count", d_cnt, 12);

    // sample-and-hold ignores vin after START
    vin = 12'h123;
    tick(23);
    vin = 12'hABC;
    tick(8);
    chk("sh_e13_valid", sample_valid, 1'b0);
    tick(1);
    chk("sh_sample", sample, 12'h123);
    next_sample("sh_next", 12'hABC);

    // stuck conversion-complete: timeout after 16 CONVERT cycles
    stuck = 1'b1;
    tick(18);
    v_cnt = 0;
    tick(16);
    chk("to_e16_error", error, 1'b0);
    chk("to_e16_busy", busy, 1'b1);
    tick(1);
    chk("to_e17_error", error, 1'b1);
    chk("to_e17_busy", busy, 1'b0);
    chk("to_e17_sar_s", sar_s, 1'b1);
    chk("to_no_valid", v_cnt, 0);
    tick(32);
    chk("to_sticky", error, 1'b1);
    chk("to_no_valid2", v_cnt, 0);
    stuck = 1'b0;
    tick(29);
    chk("to_recover_valid", sample_valid, 1'b1);
    chk("to_recover_sample", sample, 12'hABC);
    chk("to_recover_error", error, 1'b1);

    // reset in the middle of a conversion
    tick(18);
    tick(7);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sar_s", sar_s, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_error", error, 1'b0);
    chk("mid_rst_sample", sample, 12'h000);
    chk("mid_rst_valid", sample_valid, 1'b0);
    v = rand_code();
    vin = v;
    tick(2);
    reset_n = 1'b1;
    tick(15);
    chk("post_rst_valid", sample_valid, 1'b1);
    chk("post_rst_sample", sample, v);

    for (int i = 0; i < 6; i++) begin
      v = rand_code();
      vin = v;
      next_sample($sformatf("rand%0d", i), v);
    end

    // enable dropped during conversion
    tick(18);
    tick(4);
    enable = 1'b0;
    tick(10);
    chk("dis_valid", sample_valid, 1'b1);
    chk("dis_sample", sample, v);
    tick(1);
    chk("dis_sar_s", sar_s, 1'b0);
    chk("dis_busy", busy, 1'b0);
    v_cnt = 0;
    tick(40);
    chk("dis_quiet", v_cnt, 0);
    chk("dis_idle_busy", busy, 1'b0);

    // error is cleared when restarting from IDLE
    stuck = 1'b1;
    enable = 1'b1;
    tick(18);
    chk("clr_set", error, 1'b1);
    enable = 1'b0;
    stuck = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(1);
    chk("clr_in_start", error, 1'b1);
    tick(1);
    chk("clr_cleared", error, 1'b0);
    tick(13);
    chk("clr_sample", sample, v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
